muldiv_unit: RTL and testbench

Parametrised multiply/divide unit with architectural HI/LO registers for the execute stage. It runs a pipelined multiplier with configurable depth and an iterative radix-2 divider. It provides cancellation for exception flushes and an optional multiply-accumulate mode. The execute stage issues one request at a time and reads HI/LO directly for MFHI/MFLO forwarding.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_div_iter.sv | 107 ++++++++++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcodes, decode helpers and divider state encodings for muldiv_unit.
package muldiv_pkg;

  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_MULU  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam logic [1:0] DIV_IDLE  = 2'd0;
  localparam logic [1:0] DIV_PREP  = 2'd1;
  localparam logic [1:0] DIV_ITER  = 2'd2;
  localparam logic [1:0] DIV_FIXUP = 2'd3;

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Iterative radix-2 restoring divider, fixed latency XLEN+2 from start.
//   state | meaning
//   IDLE  | waiting for start, operands captured on start
//   PREP  | magnitudes and signs recorded
//   ITER  | one quotient bit per cycle, cnt XLEN-1 down to 0
//   FIXUP | signs applied, special cases resolved, complete high
module div_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            cancel_i,
  output logic            busy_o,
  output logic            complete_o,
  output logic [XLEN-1:0] q_o,
  output logic [XLEN-1:0] r_o
);
  localparam int CW = $clog2(XLEN);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
  logic            sgn_q, sgn_d, na_q, na_d, nb_q, nb_d, zero_q, zero_d;
  logic [XLEN:0]   shifted, diff;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    na_d    = na_q;
    nb_d    = nb_q;
    zero_d  = zero_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d = DIV_PREP;
          a_d     = a_i;
          b_d     = b_i;
          sgn_d   = signed_i;
        end
      end
      DIV_PREP: begin
        na_d    = sgn_q & a_q[XLEN-1];
        nb_d    = sgn_q & b_q[XLEN-1];
        quo_d   = na_d ? -a_q : a_q;
        b_d     = nb_d ? -b_q : b_q;
        rem_d   = '0;
        zero_d  = (b_q == '0);
        cnt_d   = CW'(XLEN - 1);
        state_d = DIV_ITER;
      end
      DIV_ITER: begin
        rem_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DIV_FIXUP;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (cancel_i) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      zero_q  <= zero_d;
    end
  end

  // MIN/-1 falls out naturally: magnitude 2^(XLEN-1) negated wraps to MIN.
  assign busy_o     = (state_q != DIV_IDLE);
  assign complete_o = (state_q == DIV_FIXUP);
  assign q_o        = zero_q ? '1  : ((na_q ^ nb_q) ? -quo_q : quo_q);
  assign r_o        = zero_q ? a_q : (na_q ? -rem_q : rem_q);

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO: pipelined multiplier, iterative divider.
// Define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int PW = 2 * XLEN;

  logic                  accept, kill, mul_start, div_start, mul_last, mul_wr, div_wr, acc_busy;
  logic [MUL_STAGES-1:0] mvld_q, mvld_d;
  logic [PW-1:0]         prod_q [MUL_STAGES];
  logic [PW-1:0]         ext_a, ext_b, prod_in;
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic                  done_q, done_d;
  logic                  div_busy, div_complete;
  logic [XLEN-1:0]       div_quo, div_rem;

  assign busy      = (|mvld_q) | acc_busy | div_busy;
  assign req_ready = ~busy;
  assign accept    = req_valid & req_ready;
  assign kill      = cancel & busy;
  assign div_start = accept & is_div(req_op);
`ifdef MULDIV_MADD_EN
  assign mul_start = accept & (is_mul(req_op) | is_acc(req_op));
`else
  assign mul_start = accept & is_mul(req_op);
`endif

  // Sign-extended operands make the low 2*XLEN bits correct for both signednesses.
  assign ext_a    = is_signed(req_op) ? {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
  assign ext_b    = is_signed(req_op) ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
  assign prod_in  = ext_a * ext_b;
  assign mvld_d   = kill ? '0 : ((mvld_q << 1) | MUL_STAGES'(mul_start));
  assign mul_last = mvld_q[MUL_STAGES-1] & ~kill;

  always_ff @(posedge clk) begin
    prod_q[0] <= prod_in;
    for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
  end

`ifdef MULDIV_MADD_EN
  logic [MUL_STAGES-1:0] acc_tag_q, sub_tag_q;
  logic                  accv_q, accsub_q, acc_wr;
  logic [PW-1:0]         accp_q, acc_sum;

  assign mul_wr   = mul_last & ~acc_tag_q[MUL_STAGES-1];
  assign acc_wr   = accv_q & ~kill;
  assign acc_busy = accv_q;
  assign acc_sum  = accsub_q ? ({hi_q, lo_q} - accp_q) : ({hi_q, lo_q} + accp_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) accv_q <= 1'b0;
    else         accv_q <= mul_last & acc_tag_q[MUL_STAGES-1];
  end

  // Tags shift every cycle in lockstep with the valid chain.
  always_ff @(posedge clk) begin
    acc_tag_q <= (acc_tag_q << 1) | MUL_STAGES'(is_acc(req_op));
    sub_tag_q <= (sub_tag_q << 1) | MUL_STAGES'(is_sub(req_op));
    accp_q    <= prod_q[MUL_STAGES-1];
    accsub_q  <= sub_tag_q[MUL_STAGES-1];
  end
`else
  assign mul_wr   = mul_last;
  assign acc_busy = 1'b0;
`endif

  div_iter #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (div_start),
    .signed_i   (is_signed(req_op)),
    .a_i        (src_a),
    .b_i        (src_b),
    .cancel_i   (kill),
    .busy_o     (div_busy),
    .complete_o (div_complete),
    .q_o        (div_quo),
    .r_o        (div_rem)
  );

  assign div_wr = div_complete & ~kill;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (accept && req_op == OP_MTHI) hi_d = src_a;
    if (accept && req_op == OP_MTLO) lo_d = src_a;
    if (mul_wr) begin
      {hi_d, lo_d} = prod_q[MUL_STAGES-1];
      done_d       = 1'b1;
    end
`ifdef MULDIV_MADD_EN
    if (acc_wr) begin
      {hi_d, lo_d} = acc_sum;
      done_d       = 1'b1;
    end
`endif
    if (div_wr) begin
      hi_d   = div_rem;
      lo_d   = div_quo;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mvld_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      mvld_q <= mvld_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, MUL_STAGES=3): vector table,
// hand-written corner sequences and randomized ops against a reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XL = 32;
  localparam int MS = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [XL-1:0] src_a, src_b;
  logic          cancel;
  logic          busy, done;
  logic [XL-1:0] hi, lo;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [XL-1:0] m_hi = '0, m_lo = '0;
  bit            idle_cancel = 1'b0;

  muldiv_unit #(.XLEN(XL), .MUL_STAGES(MS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 5ms");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one op applied to the current {hi,lo}.
  function automatic logic [63:0] ref_result(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                             logic [63:0] acc);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MUL:  return 64'(sa * sb);
      OP_MULU: return {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OP_MTHI: return {a, acc[31:0]};
      OP_MTLO: return {acc[63:32], a};
`ifdef MULDIV_MADD_EN
      OP_MADD:  return acc + 64'(sa * sb);
      OP_MADDU: return acc + ({32'b0, a} * {32'b0, b});
      OP_MSUB:  return acc - 64'(sa * sb);
      OP_MSUBU: return acc - ({32'b0, a} * {32'b0, b});
`endif
      default: return acc;
    endcase
  endfunction

  function automatic int ref_lat(logic [3:0] op);
    case (op)
      OP_MUL, OP_MULU: return MS;
      OP_DIV, OP_DIVU: return XL + 2;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MS + 1;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble inputs after acceptance, check timing and result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    int lat;
    lat = ref_lat(op);
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    cancel    = idle_cancel;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cancel    = 1'b0;
    req_op    = 4'($urandom_range(0, 9));
    src_a     = $urandom;
    src_b     = $urandom;
    if (lat == 0) begin
      check({tag, "_busy0"}, 64'(busy), 64'd0);
      check({tag, "_done0"}, 64'(done), 64'd0);
    end else begin
      repeat (lat - 1) @(posedge clk);
      #1;
      check({tag, "_busy_pre"}, 64'(busy), 64'd1);
      check({tag, "_done_pre"}, 64'(done), 64'd0);
      @(posedge clk); #1;
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy_post"}, 64'(busy), 64'd0);
    end
    check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[11];

  initial begin
    int n_done;

    vt[0]  = '{OP_MUL,  32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vt[1]  = '{OP_MULU, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA};
    vt[2]  = '{OP_DIVU, 32'd100,       32'd7,          32'd2,         32'd14};
    vt[3]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[4]  = '{OP_DIV,  32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
    vt[5]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    vt[6]  = '{OP_DIVU, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vt[7]  = '{OP_DIV,  32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    vt[8]  = '{OP_MUL,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0};
    vt[9]  = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1,          32'd0,         32'hFFFF_FFFF};
    vt[10] = '{OP_DIV,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};

    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    src_a     = '0;
    src_b     = '0;
    cancel    = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 11; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo}, $sformatf("vec%0d", i));

    // Accumulate from a preset {hi,lo}.
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, {m_hi, 32'hFFFF_FFFF}, "mtlo");
    run_op(OP_MTHI, 32'h0, 32'd0, {32'h0, m_lo}, "mthi");
`ifdef MULDIV_MADD_EN
    run_op(OP_MADDU, 32'd1, 32'd1, 64'h0000_0001_0000_0000, "maddu");
    run_op(OP_MSUB, 32'd2, 32'd3, 64'h0000_0000_FFFF_FFFA, "msub");
`else
    run_op(OP_MADDU, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF, "maddu_off");
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (busy || done) n_done++;
    end
    check("maddu_off_quiet", 64'(n_done), 64'd0);
`endif

    // Cancel a divide ten cycles in.
    run_op(OP_MTHI, 32'hAAAA_5555, 32'd0, {32'hAAAA_5555, m_lo}, "pre_hi");
    run_op(OP_MTLO, 32'h0000_1234, 32'd0, {m_hi, 32'h0000_1234}, "pre_lo");
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("cancel_busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy_after", 64'(busy), 64'd0);
    check("cancel_ready_after", 64'(req_ready), 64'd1);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("cancel_no_done", 64'(n_done), 64'd0);
    check("cancel_hi", 64'(hi), 64'h0000_0000_AAAA_5555);
    check("cancel_lo", 64'(lo), 64'h0000_0000_0000_1234);
    run_op(OP_MUL, 32'd6, 32'd7, 64'd42, "post_cancel_mul");

    // Cancel mid multiply pipeline.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MUL; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("mcancel_busy", 64'(busy), 64'd0);
    n_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("mcancel_no_done", 64'(n_done), 64'd0);
    check("mcancel_lo", 64'(lo), 64'd42);

    // Cancel while idle must not disturb an op accepted in the same cycle.
    idle_cancel = 1'b1;
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2, "idle_cancel_div");
    idle_cancel = 1'b0;

    // Reset in the middle of a multiply.
    run_op(OP_MTHI, 32'h1111_2222, 32'd0, {32'h1111_2222, m_lo}, "rpre_hi");
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MULU; src_a = 32'd123; src_b = 32'd456;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rmid_hi", 64'(hi), 64'd0);
    check("rmid_lo", 64'(lo), 64'd0);
    check("rmid_busy", 64'(busy), 64'd0);
    check("rmid_done", 64'(done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || busy || hi != 0 || lo != 0) n_done++;
    end
    check("rmid_no_late_write", 64'(n_done), 64'd0);
    m_hi = '0;
    m_lo = '0;

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 9));
      a  = rand_opnd();
      b  = rand_opnd();
      run_op(op, a, b, ref_result(op, a, b, {m_hi, m_lo}), $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
